// File: rtl/seg_display_ctrl.sv
// Multi-channel signed-value driver for an active-low seven-segment bank.
// Picks a channel (manual or auto-scan) and converts it with a sequential double-dabble.
module seg_display_ctrl #(
  parameter int unsigned N_CH        = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_CYC = 500000,
  parameter int unsigned SCAN_CYC    = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*DATA_W-1:0]    ch_data,
  input  logic [$clog2(N_CH)-1:0]   sel,
  input  logic                      auto_scan,
  input  logic                      hex_mode,
  input  logic                      blank_lz,
  output logic [N_DIGITS*7-1:0]     seg_digits,
  output logic [6:0]                seg_sign,
  output logic [6:0]                seg_chan,
  output logic [$clog2(N_CH)-1:0]   ch_idx,
  output logic                      overflow,
  output logic                      busy,
  output logic                      conv_done
);

  localparam int unsigned SEL_W  = $clog2(N_CH);
  localparam int unsigned BCD_N  = ((DATA_W + 2) / 3 > N_DIGITS) ? (DATA_W + 2) / 3 : N_DIGITS;
  localparam int unsigned BCD_W  = 4 * BCD_N;
  localparam int unsigned REF_W  = $clog2(REFRESH_CYC + 1);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYC + 1);
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam longint unsigned MAX_DEC = (64'd10 ** N_DIGITS) - 64'd1;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_DONE} state_t;

  state_t              state;
  logic [REF_W-1:0]    ref_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic                first_q;
  logic                pending;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   mag_q;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    bit_cnt;
  logic                sign_q;
  logic                sat_q;
  logic                hex_q;
  logic                blank_q;
  logic [SEL_W-1:0]    idx_q;

  logic [SEL_W-1:0]    ch_idx_nxt;
  logic                ref_hit;
  logic                scan_hit;
  logic                trig;
  logic [DATA_W-1:0]   word_c;
  logic                neg_c;
  logic [DATA_W-1:0]   mag_c;
  logic                sat_c;
  logic [BCD_W-1:0]    bcd_adj;
  logic [N_DIGITS*7-1:0] digits_c;
  logic                hex_ovf_c;
  logic [3:0]          nib;
  logic                lead;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Channel selection and conversion triggers
  assign ref_hit  = (ref_cnt == REF_W'(REFRESH_CYC - 1));
  assign scan_hit = auto_scan && (scan_cnt == SCAN_W'(SCAN_CYC - 1));

  always_comb begin
    ch_idx_nxt = ch_idx;
    if (auto_scan) begin
      if (scan_hit)
        ch_idx_nxt = (ch_idx == SEL_W'(N_CH - 1)) ? '0 : ch_idx + SEL_W'(1);
    end else begin
      ch_idx_nxt = (32'(sel) >= N_CH) ? '0 : sel;
    end
  end

  assign trig = first_q | ref_hit | (ch_idx_nxt != ch_idx);

  // Magnitude held unsigned so the most negative word converts correctly
  assign word_c = ch_data[32'(ch_idx) * DATA_W +: DATA_W];
  assign neg_c  = word_c[DATA_W-1] & ~hex_mode;
  assign mag_c  = neg_c ? (~word_c + DATA_W'(1)) : word_c;
  assign sat_c  = ~hex_mode && (64'(mag_c) > MAX_DEC);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(BCD_N); i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Hex overflow: bits above the shown field must repeat its msb
  always_comb begin
    hex_ovf_c = 1'b0;
    for (int i = int'(4 * N_DIGITS); i < int'(DATA_W); i++)
      if (word_q[i] != word_q[4*N_DIGITS-1]) hex_ovf_c = 1'b1;
  end

  // Digit glyphs with optional leading-zero blanking, scanned from the top digit down
  always_comb begin
    digits_c = '1;
    nib      = '0;
    lead     = blank_q;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      if (hex_q)      nib = word_q[4*k +: 4];
      else if (sat_q) nib = 4'd9;
      else            nib = bcd[4*k +: 4];
      if (nib != 4'd0 || k == 0) lead = 1'b0;
      if (!lead) digits_c[7*k +: 7] = glyph(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ref_cnt    <= '0;
      scan_cnt   <= '0;
      first_q    <= 1'b1;
      pending    <= 1'b0;
      word_q     <= '0;
      mag_q      <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      sign_q     <= 1'b0;
      sat_q      <= 1'b0;
      hex_q      <= 1'b0;
      blank_q    <= 1'b0;
      idx_q      <= '0;
      ch_idx     <= '0;
      seg_digits <= '1;
      seg_sign   <= 7'h7F;
      seg_chan   <= 7'h7F;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      conv_done  <= 1'b0;
    end else begin
      first_q   <= 1'b0;
      conv_done <= 1'b0;
      ch_idx    <= ch_idx_nxt;
      ref_cnt   <= ref_hit ? '0 : ref_cnt + REF_W'(1);
      scan_cnt  <= (!auto_scan || scan_hit) ? '0 : scan_cnt + SCAN_W'(1);
      case (state)
        S_IDLE: begin
          if (trig) begin
            state <= S_LATCH;
            busy  <= 1'b1;
          end
        end
        S_LATCH: begin
          if (trig) pending <= 1'b1;
          word_q  <= word_c;
          mag_q   <= mag_c;
          sign_q  <= neg_c && (mag_c != '0);
          sat_q   <= sat_c;
          hex_q   <= hex_mode;
          blank_q <= blank_lz;
          idx_q   <= ch_idx;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (trig) pending <= 1'b1;
          bcd     <= BCD_W'({bcd_adj, mag_q[DATA_W-1]});
          mag_q   <= {mag_q[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_W - 1)) state <= S_DONE;
        end
        S_DONE: begin
          seg_digits <= digits_c;
          seg_sign   <= sign_q ? 7'b0111111 : 7'h7F;
          seg_chan   <= glyph(4'(idx_q));
          overflow   <= hex_q ? hex_ovf_c : sat_q;
          conv_done  <= 1'b1;
          if (pending || trig) begin
            pending <= 1'b0;
            state   <= S_LATCH;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected displays queued per trigger, compared on conv_done.
module tb_seg_display_ctrl;

  localparam int unsigned NCH = 6;
  localparam int unsigned ND  = 4;
  localparam int LAT = 34;
  localparam int REF = 1000;
  localparam int SCN = 100;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [ND*7-1:0] digits;
    logic [6:0]      sign;
    logic [6:0]      chan;
    logic            ovf;
    int              due;
    int              idx;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] val;
    logic        hx;
    logic        blz;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [31:0]      ch [NCH];
  logic [NCH*32-1:0] ch_data;
  logic [2:0]       sel;
  logic             auto_scan;
  logic             hex_mode;
  logic             blank_lz;
  logic [ND*7-1:0]  seg_digits;
  logic [6:0]       seg_sign;
  logic [6:0]       seg_chan;
  logic [2:0]       ch_idx;
  logic             overflow;
  logic             busy;
  logic             conv_done;

  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb [$];
  exp_t mon_e;

  vec_t vecs [13] = '{
    '{0, 32'd1234,       1'b0, 1'b0},
    '{2, 32'hFFFFFFC8,   1'b0, 1'b1},
    '{1, 32'h80000000,   1'b0, 1'b0},
    '{1, 32'd12345,      1'b0, 1'b0},
    '{0, 32'hFFFFFFFE,   1'b1, 1'b0},
    '{0, 32'h00012345,   1'b1, 1'b0},
    '{4, 32'd0,          1'b0, 1'b1},
    '{5, 32'd9999,       1'b0, 1'b1},
    '{3, 32'd10000,      1'b0, 1'b0},
    '{5, 32'hFFFFD8F1,   1'b0, 1'b0},
    '{3, 32'h000000A0,   1'b1, 1'b1},
    '{2, 32'd7,          1'b0, 1'b1},
    '{4, 32'h80000000,   1'b1, 1'b0}
  };

  assign ch_data = {ch[5], ch[4], ch[3], ch[2], ch[1], ch[0]};

  seg_display_ctrl #(
    .N_CH(NCH), .DATA_W(32), .N_DIGITS(ND), .REFRESH_CYC(REF), .SCAN_CYC(SCN)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .sel(sel), .auto_scan(auto_scan),
    .hex_mode(hex_mode), .blank_lz(blank_lz), .seg_digits(seg_digits), .seg_sign(seg_sign),
    .seg_chan(seg_chan), .ch_idx(ch_idx), .overflow(overflow), .busy(busy), .conv_done(conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference display for one word, computed arithmetically
  function automatic exp_t model(input logic [31:0] w, input logic hx, input logic blz,
                                 input int chn, input int due, input int idx);
    exp_t        e;
    logic        neg;
    logic [31:0] mag;
    logic [31:0] p;
    logic [3:0]  nb [ND];
    int          top;
    neg = w[31] & ~hx;
    mag = neg ? (32'd0 - w) : w;
    if (hx) begin
      for (int k = 0; k < int'(ND); k++) nb[k] = w[4*k +: 4];
      e.ovf = (w[31:16] != {16{w[15]}});
    end else begin
      e.ovf = (mag > 32'd9999);
      p = 32'd1;
      for (int k = 0; k < int'(ND); k++) begin
        nb[k] = e.ovf ? 4'd9 : 4'((mag / p) % 32'd10);
        p = p * 32'd10;
      end
    end
    top = 0;
    for (int k = 0; k < int'(ND); k++) if (nb[k] != 4'd0) top = k;
    for (int k = 0; k < int'(ND); k++)
      e.digits[7*k +: 7] = (blz && k > top) ? 7'h7F : GLYPH[nb[k]];
    e.sign = (neg && mag != 32'd0) ? 7'h3F : 7'h7F;
    e.chan = GLYPH[4'(chn)];
    e.due  = due;
    e.idx  = idx;
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (conv_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(conv_done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("digits",   64'(seg_digits), 64'(mon_e.digits));
        check("sign",     64'(seg_sign),   64'(mon_e.sign));
        check("chan",     64'(seg_chan),   64'(mon_e.chan));
        check("overflow", 64'(overflow),   64'(mon_e.ovf));
        if (mon_e.due >= 0) check("latency", 64'(cyc), 64'(mon_e.due));
        if (mon_e.idx >= 0) check("ch_idx", 64'(ch_idx), 64'(mon_e.idx));
      end
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_digits"}, 64'(seg_digits), 64'({ND{7'h7F}}));
    check({tag, "_sign"},   64'(seg_sign),   64'(7'h7F));
    check({tag, "_chan"},   64'(seg_chan),   64'(7'h7F));
    check({tag, "_ch_idx"}, 64'(ch_idx),     64'(0));
    check({tag, "_ovf"},    64'(overflow),   64'(0));
    check({tag, "_busy"},   64'(busy),       64'(0));
    check({tag, "_done"},   64'(conv_done),  64'(0));
  endtask

  // One reset edge; t0 is the cycle stamp of the first edge after release
  task automatic do_reset(output int t0);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'(0));
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    n_checks = 0;
    n_err = 0;
    rst = 1'b1;
    sel = 3'd0;
    auto_scan = 1'b0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    for (int i = 0; i < int'(NCH); i++) ch[i] = 32'(i * 11);

    // Single conversions across modes and boundary values
    foreach (vecs[i]) begin
      @(negedge clk);
      ch[vecs[i].sel] = vecs[i].val;
      sel      = 3'(vecs[i].sel);
      hex_mode = vecs[i].hx;
      blank_lz = vecs[i].blz;
      do_reset(t0);
      sb.push_back(model(vecs[i].val, vecs[i].hx, vecs[i].blz, vecs[i].sel, t0 + LAT, vecs[i].sel));
      wait_drain(100);
    end

    // Select change mid-conversion: frozen word, then direct restart on the new channel
    @(negedge clk);
    ch[0] = 32'd1234;
    ch[3] = 32'd777;
    sel = 3'd0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    do_reset(t0);
    sb.push_back(model(32'd1234, 1'b0, 1'b0, 0, t0 + LAT, -1));
    sb.push_back(model(32'd777, 1'b0, 1'b0, 3, t0 + 2 * LAT, 3));
    while (cyc < t0 + 10) @(negedge clk);
    sel = 3'd3;
    ch[0] = 32'd5555;
    while (cyc < t0 + LAT) @(negedge clk);
    check("restart_busy", 64'(busy), 64'(1));
    wait_drain(100);

    // Auto-scan walks every channel and wraps
    @(negedge clk);
    for (int k = 0; k < int'(NCH); k++) ch[k] = 32'(k * 1111 - 2000);
    auto_scan = 1'b1;
    sel = 3'd4;
    do_reset(t0);
    sb.push_back(model(ch[0], 1'b0, 1'b0, 0, t0 + LAT, 0));
    for (int k = 1; k <= int'(NCH); k++)
      sb.push_back(model(ch[k % NCH], 1'b0, 1'b0, k % NCH, t0 + SCN * k - 1 + LAT, k % NCH));
    wait_drain(800);
    auto_scan = 1'b0;

    // Reset in the middle of a shift clears every output on the next edge
    @(negedge clk);
    sel = 3'd0;
    do_reset(t0);
    sb.push_back(model(ch[0], 1'b0, 1'b0, 0, t0 + LAT, 0));
    wait_drain(100);
    sel = 3'd2;
    repeat (12) @(negedge clk);
    check("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid_reset");
    rst = 1'b0;
    t0 = cyc + 1;
    sb.push_back(model(ch[2], 1'b0, 1'b0, 2, t0 + LAT, 2));
    wait_drain(100);

    // Periodic refresh re-samples the channel
    @(negedge clk);
    sel = 3'd5;
    ch[5] = 32'd4321;
    do_reset(t0);
    sb.push_back(model(32'd4321, 1'b0, 1'b0, 5, t0 + LAT, 5));
    wait_drain(100);
    ch[5] = 32'hFFFFFFB3;
    sb.push_back(model(32'hFFFFFFB3, 1'b0, 1'b0, 5, t0 + REF - 1 + LAT, 5));
    wait_drain(1100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised, sequential multi-channel signed-value display driver for the DE2-115 seven-segment bank.
- Selects one of N_CH signed channels (IMU velocity or gyro data), either manually or by auto-scan, and converts it with an iterative double-dabble.
- Drives N_DIGITS decimal or hex digits plus a sign digit and a channel-index digit, all active-low.
- Replaces the top level's combinational divide/modulo display path.

Parameters:
- N_CH, 6, number of input channels (2..16)
- DATA_W, 32, width of each signed channel word
- N_DIGITS, 4, magnitude digits displayed (1..6)
- REFRESH_CYC, 500000, clocks between conversion triggers (10 ms at 50 MHz)
- SCAN_CYC, 100000000, clocks per channel in auto-scan mode (2 s)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- ch_data  in  N_CH*DATA_W  packed signed channels, channel i at bits [i*DATA_W +: DATA_W]
- sel  in  $clog2(N_CH)  manual channel select; values >= N_CH map to channel 0
- auto_scan  in  1  1 = rotate channels automatically; sel is ignored
- hex_mode  in  1  1 = raw two's-complement hex, no sign handling
- blank_lz  in  1  1 = blank leading zeros
- seg_digits  out  N_DIGITS*7  active-low segments, digit 0 (least significant) in bits [6:0]
- seg_sign  out  7  '-' (7'b0111111) or off (7'h7F)
- seg_chan  out  7  hex glyph of the displayed channel index
- ch_idx  out  $clog2(N_CH)  channel currently displayed
- overflow  out  1  displayed magnitude was saturated
- busy  out  1  conversion in progress
- conv_done  out  1  one-cycle pulse when the outputs update

Behaviour:
- Reset values:
  - seg_digits all 7'h7F, seg_sign 7'h7F, seg_chan 7'h7F
  - ch_idx 0, overflow 0, busy 0, conv_done 0
  - refresh and scan counters 0, FSM in IDLE, pending flag 0
- Reset mid-conversion aborts immediately; every output takes its reset value on the next edge.
- Triggers:
  - refresh counter reaching REFRESH_CYC-1 (counter then wraps to 0)
  - a change of the effective channel index
  - the first cycle after rst deasserts
- A trigger arriving while busy sets pending. On leaving DONE, pending=1 causes a direct restart through LATCH and clears pending.
- Channel select:
  - auto_scan=1: scan counter wraps at SCAN_CYC-1 and ch_idx advances, wrapping N_CH-1 -> 0.
  - auto_scan=0: ch_idx follows the registered sel each cycle.
  - Switching auto_scan from 1 to 0 clears the scan counter.
- FSM IDLE -> LATCH -> SHIFT -> DONE -> IDLE:
  - IDLE: on trigger go to LATCH; busy=1 from the LATCH cycle onward.
  - LATCH:
    - capture the channel word and compute neg = word[DATA_W-1] & ~hex_mode.
    - mag = neg ? -word : word, held as DATA_W-bit unsigned, so -2^(DATA_W-1) is represented correctly.
    - sat = mag > 10^N_DIGITS-1 (decimal only).
    - clear the BCD register.
  - SHIFT: exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts left by 1, taking the msb of mag. In hex_mode the shifting still runs and its result is discarded.
  - DONE: register all outputs, pulse conv_done=1, set busy=0.
- Latency: outputs and conv_done appear DATA_W+2 cycles after the trigger edge, identical for every mode and value.
- Decimal output:
  - if sat, every digit is 9 and overflow=1; otherwise BCD digits and overflow=0.
  - seg_sign='-' iff neg and mag != 0.
- Hex output: digit k = word[4k+3:4k] (glyphs A-F); overflow=1 iff the upper bits are not pure sign extension of the displayed field; seg_sign off.
- Leading-zero blanking (blank_lz=1): every digit above the highest nonzero digit is 7'h7F; a value of 0 still shows a single '0' in digit 0.
- seg_chan always shows the hex glyph of ch_idx, latched in DONE.
- Input changes during SHIFT do not affect the current result; the channel word is frozen in LATCH.

Test Plan:
- Reset, then ch0=1234, sel=0, decimal, blank_lz=0 → after 34 cycles conv_done pulses; digits 1,2,3,4; seg_sign off; overflow=0; seg_chan '0'.
- ch2=-56, sel=2, blank_lz=1 → digits 3,2 blank; digits show 5,6; seg_sign=7'b0111111; seg_chan '2'.
- ch1=32'h80000000, then ch1=12345, sel=1 → both give digits 9999 and overflow=1; the first also has seg_sign '-'.
- hex_mode=1, ch0=-2 → digits F,F,F,E; seg_sign off; overflow=0. Then ch0=32'h00012345 → digits 2,3,4,5 and overflow=1.
- Change sel from 0 to 3 during SHIFT → the current conversion finishes with ch0; a second conversion starts from LATCH with no IDLE cycle and ends with ch_idx=3. With REFRESH_CYC=8, conversions occur back-to-back.
- auto_scan=1, SCAN_CYC=100, N_CH=6 → ch_idx runs 0..5, 0 every 100 cycles. Asserting rst mid-SHIFT → all outputs take reset values on the next edge.
